decoder_scan: RTL and testbench

Parametrised registered one-hot decoder with a built-in scan sequencer. It generalises the fixed 3-to-8 combinational decoder to an IN_W-to-2^IN_W decoder. Direct mode decodes a loaded select value; scan mode steps automatically through indices 0..last with a programmable dwell per index. It drives board-level multiplexed selects (7-segment digit enables, LED matrix rows, bank selects) from the system clock domain.

---
 rtl/decoder_scan.sv | 82 ++++++++
 tb/tb_decoder_scan.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan.sv
// Registered IN_W-to-2^IN_W one-hot decoder with a direct-load mode and an
// automatic scan sequencer that dwells dwell+1 cycles on each index 0..last.
module decoder_scan #(
    parameter int unsigned IN_W       = 3,
    parameter int unsigned DWELL_W    = 16,
    parameter bit          ACTIVE_LOW = 1'b0,
    localparam int unsigned OUT_W     = 1 << IN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [IN_W-1:0]    sel_in,
    input  logic               sel_valid,
    input  logic [IN_W-1:0]    last,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   out,
    output logic [IN_W-1:0]    idx,
    output logic               wrap
);

    localparam logic [OUT_W-1:0] POL_MASK = {OUT_W{ACTIVE_LOW}};

    logic [IN_W-1:0]    idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               wrap_q, wrap_d;

    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (!mode) begin
            // Direct mode: loads are accepted regardless of en.
            cnt_d = '0;
            if (sel_valid) begin
                idx_d = sel_in;
            end
        end else if (en) begin
            // >= so that lowering dwell or last mid-dwell takes effect at once.
            if (cnt_q >= dwell) begin
                cnt_d = '0;
                if (idx_q >= last) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q + IN_W'(1);
                end
            end else begin
                cnt_d = cnt_q + DWELL_W'(1);
            end
        end
    end

    // out tracks the index that idx will hold after this edge.
    always_comb begin
        out_d = '0;
        if (en) begin
            out_d = OUT_W'(1) << idx_d;
        end
        out_d = out_d ^ POL_MASK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            out_q  <= POL_MASK;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign out  = out_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan (IN_W=3), with an active-low twin instance
// sharing all inputs.
module tb_decoder_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic [2:0]  sel_in;
    logic        sel_valid;
    logic [2:0]  last;
    logic [15:0] dwell;
    logic [7:0]  out, out_al;
    logic [2:0]  idx, idx_al;
    logic        wrap, wrap_al;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoder_scan #(.IN_W(3), .DWELL_W(16), .ACTIVE_LOW(1'b0)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in),
        .sel_valid(sel_valid), .last(last), .dwell(dwell),
        .out(out), .idx(idx), .wrap(wrap)
    );

    decoder_scan #(.IN_W(3), .DWELL_W(16), .ACTIVE_LOW(1'b1)) u_dut_al (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in),
        .sel_valid(sel_valid), .last(last), .dwell(dwell),
        .out(out_al), .idx(idx_al), .wrap(wrap_al)
    );

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 1'b0; sel_in = 3'd0; sel_valid = 1'b0;
        last = 3'd7; dwell = 16'd0;
        step();
        step();
        checks++; if (out !== 8'h00) begin errors++;
            $display("FAIL reset_out got %h exp %h", out, 8'h00); end
        checks++; if (idx !== 3'd0) begin errors++;
            $display("FAIL reset_idx got %0d exp 0", idx); end
        checks++; if (wrap !== 1'b0) begin errors++;
            $display("FAIL reset_wrap got %b exp 0", wrap); end
        checks++; if (out_al !== 8'hFF) begin errors++;
            $display("FAIL reset_out_al got %h exp %h", out_al, 8'hFF); end
    endtask

    task automatic test_direct();
        logic [7:0] exp;
        rst = 1'b0; mode = 1'b0; en = 1'b1;
        sel_in = 3'd5; sel_valid = 1'b1;
        step();
        checks++; if (out !== 8'h20) begin errors++;
            $display("FAIL direct_load_out got %h exp 20", out); end
        checks++; if (idx !== 3'd5) begin errors++;
            $display("FAIL direct_load_idx got %0d exp 5", idx); end
        checks++; if (out_al !== 8'hDF) begin errors++;
            $display("FAIL direct_load_out_al got %h exp df", out_al); end
        sel_in = 3'd2; sel_valid = 1'b0;
        step();
        checks++; if (out !== 8'h20 || idx !== 3'd5) begin errors++;
            $display("FAIL direct_hold got out=%h idx=%0d exp out=20 idx=5", out, idx); end
        for (int i = 0; i < 8; i++) begin
            sel_in = 3'(i); sel_valid = 1'b1;
            step();
            exp = 8'h01 << i;
            checks++; if (out !== exp || idx !== 3'(i)) begin errors++;
                $display("FAIL direct_sweep%0d got out=%h idx=%0d exp out=%h idx=%0d",
                         i, out, idx, exp, i); end
        end
        // Load while disabled: idx updates, out stays inactive.
        en = 1'b0; sel_in = 3'd6; sel_valid = 1'b1;
        step();
        checks++; if (out !== 8'h00 || idx !== 3'd6) begin errors++;
            $display("FAIL direct_en0_load got out=%h idx=%0d exp out=00 idx=6", out, idx); end
        en = 1'b1; sel_valid = 1'b0;
        step();
        checks++; if (out !== 8'h40) begin errors++;
            $display("FAIL direct_reenable got %h exp 40", out); end
    endtask

    task automatic test_scan_fast();
        logic [2:0] ei;
        logic       ew;
        mode = 1'b0; sel_in = 3'd0; sel_valid = 1'b1;
        step();
        mode = 1'b1; sel_valid = 1'b0; dwell = 16'd0; last = 3'd7;
        for (int k = 1; k <= 9; k++) begin
            step();
            ei = 3'(k % 8);
            ew = (k == 8);
            checks++; if (idx !== ei || out !== (8'h01 << ei) || wrap !== ew) begin errors++;
                $display("FAIL scan_fast_k%0d got idx=%0d out=%h wrap=%b exp idx=%0d out=%h wrap=%b",
                         k, idx, out, wrap, ei, 8'h01 << ei, ew); end
        end
    endtask

    task automatic test_scan_slow();
        logic [2:0] ei;
        logic       ew;
        mode = 1'b0; sel_in = 3'd0; sel_valid = 1'b1;
        step();
        mode = 1'b1; sel_valid = 1'b0; dwell = 16'd2; last = 3'd5;
        for (int n = 1; n <= 30; n++) begin
            step();
            ei = 3'((n / 3) % 6);
            ew = (n % 18 == 0);
            checks++; if (idx !== ei || out !== (8'h01 << ei) || wrap !== ew) begin errors++;
                $display("FAIL scan_slow_n%0d got idx=%0d out=%h wrap=%b exp idx=%0d out=%h wrap=%b",
                         n, idx, out, wrap, ei, 8'h01 << ei, ew); end
        end
        // Now at idx=4, cnt=0: lowering last wraps on the next advance.
        last = 3'd1;
        step();
        step();
        checks++; if (idx !== 3'd4 || wrap !== 1'b0) begin errors++;
            $display("FAIL scan_lower_hold got idx=%0d wrap=%b exp idx=4 wrap=0", idx, wrap); end
        step();
        checks++; if (idx !== 3'd0 || wrap !== 1'b1 || out !== 8'h01) begin errors++;
            $display("FAIL scan_lower_wrap got idx=%0d wrap=%b out=%h exp idx=0 wrap=1 out=01",
                     idx, wrap, out); end
        step();
        checks++; if (wrap !== 1'b0) begin errors++;
            $display("FAIL scan_wrap_pulse got %b exp 0", wrap); end
    endtask

    task automatic test_freeze();
        mode = 1'b0; sel_in = 3'd3; sel_valid = 1'b1; last = 3'd7; dwell = 16'd2;
        step();
        mode = 1'b1; sel_valid = 1'b0;
        step();
        en = 1'b0;
        step();
        checks++; if (out !== 8'h00 || idx !== 3'd3) begin errors++;
            $display("FAIL freeze_off got out=%h idx=%0d exp out=00 idx=3", out, idx); end
        checks++; if (out_al !== 8'hFF) begin errors++;
            $display("FAIL freeze_off_al got %h exp ff", out_al); end
        step();
        checks++; if (out !== 8'h00 || idx !== 3'd3) begin errors++;
            $display("FAIL freeze_hold got out=%h idx=%0d exp out=00 idx=3", out, idx); end
        en = 1'b1;
        step();
        checks++; if (out !== 8'h08 || idx !== 3'd3) begin errors++;
            $display("FAIL freeze_resume got out=%h idx=%0d exp out=08 idx=3", out, idx); end
        step();
        checks++; if (out !== 8'h10 || idx !== 3'd4) begin errors++;
            $display("FAIL freeze_advance got out=%h idx=%0d exp out=10 idx=4", out, idx); end
    endtask

    task automatic test_reset_mid();
        mode = 1'b0; sel_in = 3'd6; sel_valid = 1'b1;
        step();
        mode = 1'b1; sel_valid = 1'b0; dwell = 16'd2; last = 3'd7;
        step();
        rst = 1'b1;
        step();
        checks++; if (idx !== 3'd0 || out !== 8'h00 || wrap !== 1'b0) begin errors++;
            $display("FAIL reset_mid got idx=%0d out=%h wrap=%b exp idx=0 out=00 wrap=0",
                     idx, out, wrap); end
        checks++; if (out_al !== 8'hFF) begin errors++;
            $display("FAIL reset_mid_al got %h exp ff", out_al); end
        rst = 1'b0;
        step();
        checks++; if (out !== 8'h01 || idx !== 3'd0) begin errors++;
            $display("FAIL reset_release got out=%h idx=%0d exp out=01 idx=0", out, idx); end
        step();
        step();
        checks++; if (out !== 8'h02 || idx !== 3'd1) begin errors++;
            $display("FAIL reset_resume got out=%h idx=%0d exp out=02 idx=1", out, idx); end
    endtask

    task automatic test_back_to_back();
        // last=0, dwell=0: wrap on every edge, idx pinned at 0.
        dwell = 16'd0; last = 3'd0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (idx !== 3'd0 || wrap !== 1'b1 || out !== 8'h01) begin errors++;
                $display("FAIL last0_k%0d got idx=%0d wrap=%b out=%h exp idx=0 wrap=1 out=01",
                         k, idx, wrap, out); end
        end
        mode = 1'b0; sel_in = 3'd7; sel_valid = 1'b0;
        step();
        checks++; if (idx !== 3'd0 || wrap !== 1'b0 || out !== 8'h01) begin errors++;
            $display("FAIL to_direct got idx=%0d wrap=%b out=%h exp idx=0 wrap=0 out=01",
                     idx, wrap, out); end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan_fast();
        test_scan_slow();
        test_freeze();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
